// File: rtl/control_m_axi_write_pkg.sv
// control_m_axi_write_pkg: shared state type, constants and helpers for the AXI write burst issuer
package control_m_axi_write_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_ISSUE, ST_DRAIN} state_e;

    localparam int LP_4K_BYTES = 4096;

    function automatic int bytes_per_beat(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int log2(input int value);
        int r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/control_m_axi_write_outstanding_counter.sv
// control_m_axi_write_outstanding_counter: tracks AW bursts still waiting for their B response
module control_m_axi_write_outstanding_counter
    import control_m_axi_write_pkg::*;
#(
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   incr,
    input  logic                                   decr,
    output logic [$clog2(C_MAX_OUTSTANDING+1)-1:0] count,
    output logic                                   is_full
);

    localparam int LP_W = $clog2(C_MAX_OUTSTANDING + 1);

    logic [LP_W-1:0] count_q, count_d;
    logic            dec_ok;

    // A B response with nothing outstanding cannot be ours, so it never wraps the count below zero
    always_comb begin
        dec_ok  = decr && (count_q != '0 || incr);
        count_d = (incr == dec_ok) ? count_q : incr ? count_q + LP_W'(1) : count_q - LP_W'(1);
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;

    assign count   = count_q;
    assign is_full = count_q == LP_W'(C_MAX_OUTSTANDING);

endmodule

// File: rtl/control_m_axi_write_burst_issuer.sv
// control_m_axi_write_burst_issuer: splits a write request into 4K-safe AXI bursts, forks AW and wlen, waits for B
module control_m_axi_write_burst_issuer
    import control_m_axi_write_pkg::*;
#(
    parameter int C_ADDR_WIDTH       = 64,
    parameter int C_DATA_WIDTH       = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_MAX_BURST_LENGTH = 64,
    parameter int C_MAX_OUTSTANDING  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_num_beats,
    output logic                         ctrl_done,
    output logic                         m_axi_awvalid,
    input  logic                         m_axi_awready,
    output logic [C_ADDR_WIDTH-1:0]      m_axi_awaddr,
    output logic [7:0]                   m_axi_awlen,
    input  logic                         m_axi_bvalid,
    output logic                         m_axi_bready,
    output logic                         wlen_valid,
    input  logic                         wlen_ready,
    output logic [7:0]                   wlen
);

    localparam int LP_BPB      = bytes_per_beat(C_DATA_WIDTH);
    localparam int LP_LOG2_BPB = log2(LP_BPB);
    localparam int LP_CNT_W    = $clog2(C_MAX_OUTSTANDING + 1);

    state_e                       state_q, state_d;
    logic [C_ADDR_WIDTH-1:0]      addr_q, addr_d, addr_next;
    logic [C_XFER_SIZE_WIDTH-1:0] rem_q, rem_d, rem_next, burst;
    logic [7:0]                   len_q, len_d;
    logic [8:0]                   burst_cnt;
    logic [11:0]                  calc_off;
    logic [12:0]                  to_4k;
    logic                         aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
    logic                         done_q, done_d, bready_q, bready_d;
    logic                         aw_hs, w_hs, b_hs, retire, out_full;
    logic [LP_CNT_W-1:0]          out_count;

    control_m_axi_write_outstanding_counter #(
        .C_MAX_OUTSTANDING(C_MAX_OUTSTANDING)
    ) u_outstanding (
        .clk    (clk),
        .rst_n  (rst_n),
        .incr   (aw_hs),
        .decr   (b_hs),
        .count  (out_count),
        .is_full(out_full)
    );

    // The address channel is held back only while the B window is full; wlen is never throttled
    assign m_axi_awvalid = aw_pend_q && !out_full;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign wlen_valid    = w_pend_q;
    assign wlen          = len_q;
    assign m_axi_bready  = bready_q;
    assign ctrl_done     = done_q;
    assign aw_hs         = m_axi_awvalid && m_axi_awready;
    assign w_hs          = wlen_valid && wlen_ready;
    assign b_hs          = m_axi_bvalid && m_axi_bready;
    assign retire        = state_q == ST_ISSUE && (!aw_pend_q || aw_hs) && (!w_pend_q || w_hs);
    assign burst_cnt     = {1'b0, len_q} + 9'd1;

    // Position after the current burst, and the size of the burst that starts there (or at the request start in CALC)
    always_comb begin
        addr_next = addr_q + (C_ADDR_WIDTH'(burst_cnt) << LP_LOG2_BPB);
        rem_next  = rem_q - C_XFER_SIZE_WIDTH'(burst_cnt);
        calc_off  = state_q == ST_CALC ? addr_q[11:0] : addr_next[11:0];
        to_4k     = (13'(LP_4K_BYTES) - {1'b0, calc_off}) >> LP_LOG2_BPB;
        burst     = state_q == ST_CALC ? rem_q : rem_next;
        burst     = burst > C_XFER_SIZE_WIDTH'(C_MAX_BURST_LENGTH) ? C_XFER_SIZE_WIDTH'(C_MAX_BURST_LENGTH) : burst;
        burst     = burst > C_XFER_SIZE_WIDTH'(to_4k) ? C_XFER_SIZE_WIDTH'(to_4k) : burst;
    end

    // FSM next state, AW/wlen fork bookkeeping and completion pulse
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        len_d     = len_q;
        aw_pend_d = aw_pend_q && !aw_hs;
        w_pend_d  = w_pend_q && !w_hs;
        done_d    = 1'b0;
        bready_d  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_start) begin
                    addr_d  = ctrl_addr_offset & ~C_ADDR_WIDTH'(LP_BPB - 1);
                    rem_d   = ctrl_xfer_num_beats;
                    state_d = ctrl_xfer_num_beats == '0 ? ST_DRAIN : ST_CALC;
                end
            end
            ST_CALC: begin
                len_d     = 8'(burst - C_XFER_SIZE_WIDTH'(1));
                aw_pend_d = 1'b1;
                w_pend_d  = 1'b1;
                state_d   = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (retire) begin
                    addr_d = addr_next;
                    rem_d  = rem_next;
                    if (rem_next == '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        len_d     = 8'(burst - C_XFER_SIZE_WIDTH'(1));
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_count == '0 || (out_count == LP_CNT_W'(1) && b_hs)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            len_q     <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            done_q    <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            len_q     <= len_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            done_q    <= done_d;
            bready_q  <= bready_d;
        end

endmodule

// File: tb/tb_control_m_axi_write_burst_issuer.sv
// tb_control_m_axi_write_burst_issuer: directed and randomized checks against a burst-splitting reference model
module tb_control_m_axi_write_burst_issuer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctrl_start = 1'b0;
    logic [63:0] ctrl_addr_offset = '0;
    logic [31:0] ctrl_xfer_num_beats = '0;
    logic        ctrl_done;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [63:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic        wlen_valid;
    logic        wlen_ready = 1'b0;
    logic [7:0]  wlen;

    int checks = 0;
    int errors = 0;

    control_m_axi_write_burst_issuer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ctrl_start         (ctrl_start),
        .ctrl_addr_offset   (ctrl_addr_offset),
        .ctrl_xfer_num_beats(ctrl_xfer_num_beats),
        .ctrl_done          (ctrl_done),
        .m_axi_awvalid      (m_axi_awvalid),
        .m_axi_awready      (m_axi_awready),
        .m_axi_awaddr       (m_axi_awaddr),
        .m_axi_awlen        (m_axi_awlen),
        .m_axi_bvalid       (m_axi_bvalid),
        .m_axi_bready       (m_axi_bready),
        .wlen_valid         (wlen_valid),
        .wlen_ready         (wlen_ready),
        .wlen               (wlen)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, logs every handshake with its cycle number
    logic [63:0] mon_aw_addr[$];
    int          mon_aw_len[$];
    int          mon_aw_cyc[$];
    int          mon_w_len[$];
    int          mon_w_cyc[$];
    int          n_b = 0, last_b_cyc = 0, n_done = 0, last_done_cyc = 0, stab_err = 0;
    logic        aw_hold = 1'b0, w_hold = 1'b0;
    logic [63:0] hold_addr = '0;
    logic [7:0]  hold_awlen = '0, hold_wlen = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            aw_hold = 1'b0;
            w_hold  = 1'b0;
        end else begin
            if (aw_hold && (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== hold_addr || m_axi_awlen !== hold_awlen)) stab_err++;
            if (w_hold && (wlen_valid !== 1'b1 || wlen !== hold_wlen)) stab_err++;
            if (m_axi_awvalid && m_axi_awready) begin
                mon_aw_addr.push_back(m_axi_awaddr);
                mon_aw_len.push_back(int'(m_axi_awlen));
                mon_aw_cyc.push_back(cyc);
            end
            if (wlen_valid && wlen_ready) begin
                mon_w_len.push_back(int'(wlen));
                mon_w_cyc.push_back(cyc);
            end
            if (m_axi_bvalid && m_axi_bready) begin
                n_b++;
                last_b_cyc = cyc;
            end
            if (ctrl_done) begin
                n_done++;
                last_done_cyc = cyc;
            end
            aw_hold    = m_axi_awvalid && !m_axi_awready;
            w_hold     = wlen_valid && !wlen_ready;
            hold_addr  = m_axi_awaddr;
            hold_awlen = m_axi_awlen;
            hold_wlen  = wlen;
        end
    end

    // Driver: ready/valid probabilities in percent; B only answers bursts the slave has actually accepted
    int p_aw = 100, p_w = 100, p_b = 100, pend_adj = 0, max_pend = 0;

    task automatic tick();
        int pend;
        @(posedge clk);
        #1;
        ctrl_start    = 1'b0;
        pend          = mon_aw_addr.size() - n_b - pend_adj;
        if (pend > max_pend) max_pend = pend;
        m_axi_awready = int'($urandom_range(99)) < p_aw;
        wlen_ready    = int'($urandom_range(99)) < p_w;
        m_axi_bvalid  = pend > 0 && int'($urandom_range(99)) < p_b;
    endtask

    task automatic start(input logic [63:0] a, input int n, output int t);
        tick();
        ctrl_start          = 1'b1;
        ctrl_addr_offset    = a;
        ctrl_xfer_num_beats = n;
        t                   = cyc;
    endtask

    task automatic wait_done(input int d0, input int budget, input string nm);
        int k = 0;
        while (n_done == d0 && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (n_done == d0) begin
            errors++;
            $display("FAIL %s_timeout: ctrl_done not seen within %0d cycles", nm, budget);
        end
    endtask

    // Reference model: split the request by the 4 KB / max-burst / remaining rules
    logic [63:0] exp_addr[$];
    int          exp_len[$];

    task automatic build_model(input logic [63:0] a, input int n);
        longint unsigned room, b;
        logic [63:0] cur;
        int rem;
        cur = a & ~64'h3F;
        rem = n;
        exp_addr.delete();
        exp_len.delete();
        while (rem > 0) begin
            room = (4096 - cur % 4096) / 64;
            b = longint'(rem);
            if (b > 64) b = 64;
            if (b > room) b = room;
            exp_addr.push_back(cur);
            exp_len.push_back(int'(b) - 1);
            cur += b * 64;
            rem -= int'(b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_axi_awvalid, wlen_valid, ctrl_done, m_axi_bready} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: awvalid,wlen_valid,done,bready=%b expected 0000", {m_axi_awvalid, wlen_valid, ctrl_done, m_axi_bready});
        end
        checks++;
        if (m_axi_awaddr !== 64'h0 || {m_axi_awlen, wlen} !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: awaddr=%h awlen=%h wlen=%h expected 0", m_axi_awaddr, m_axi_awlen, wlen);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (m_axi_bready !== 1'b1) begin
            errors++;
            $display("FAIL reset_bready: got %b expected 1", m_axi_bready);
        end
    endtask

    task automatic test_basic();
        int t, a0, w0, d0;
        a0 = mon_aw_addr.size(); w0 = mon_w_len.size(); d0 = n_done;
        p_aw = 100; p_w = 100; p_b = 100;
        start(64'h0, 128, t);
        wait_done(d0, 200, "basic");
        repeat (3) tick();
        checks++;
        if (mon_aw_addr.size() - a0 != 2 || mon_w_len.size() - w0 != 2) begin
            errors++;
            $display("FAIL basic_count: aw=%0d w=%0d expected 2 2", mon_aw_addr.size() - a0, mon_w_len.size() - w0);
        end else begin
            checks++;
            if (mon_aw_addr[a0] !== 64'h0 || mon_aw_len[a0] != 63 || mon_aw_addr[a0+1] !== 64'h1000 || mon_aw_len[a0+1] != 63) begin
                errors++;
                $display("FAIL basic_aw: got %h/%0d %h/%0d expected 0/63 1000/63", mon_aw_addr[a0], mon_aw_len[a0], mon_aw_addr[a0+1], mon_aw_len[a0+1]);
            end
            checks++;
            if (mon_aw_cyc[a0] != t + 2 || mon_aw_cyc[a0+1] != t + 3) begin
                errors++;
                $display("FAIL basic_aw_timing: got t+%0d t+%0d expected t+2 t+3", mon_aw_cyc[a0] - t, mon_aw_cyc[a0+1] - t);
            end
        end
        checks++;
        if (last_done_cyc != last_b_cyc + 1 || last_done_cyc != t + 5 || n_done - d0 != 1) begin
            errors++;
            $display("FAIL basic_done: done at t+%0d (last B t+%0d, pulses %0d) expected t+5, one pulse", last_done_cyc - t, last_b_cyc - t, n_done - d0);
        end
    endtask

    task automatic test_4k();
        int t, a0, w0, d0;
        a0 = mon_aw_addr.size(); w0 = mon_w_len.size(); d0 = n_done;
        start(64'hF80, 10, t);
        wait_done(d0, 200, "4k");
        repeat (3) tick();
        checks++;
        if (mon_aw_addr.size() - a0 != 2 || mon_w_len.size() - w0 != 2) begin
            errors++;
            $display("FAIL 4k_count: aw=%0d w=%0d expected 2 2", mon_aw_addr.size() - a0, mon_w_len.size() - w0);
        end else begin
            checks++;
            if (mon_aw_addr[a0] !== 64'hF80 || mon_aw_len[a0] != 1 || mon_aw_addr[a0+1] !== 64'h1000 || mon_aw_len[a0+1] != 7) begin
                errors++;
                $display("FAIL 4k_aw: got %h/%0d %h/%0d expected f80/1 1000/7", mon_aw_addr[a0], mon_aw_len[a0], mon_aw_addr[a0+1], mon_aw_len[a0+1]);
            end
            checks++;
            if (mon_w_len[w0] != 1 || mon_w_len[w0+1] != 7) begin
                errors++;
                $display("FAIL 4k_wlen: got %0d %0d expected 1 7", mon_w_len[w0], mon_w_len[w0+1]);
            end
        end
    endtask

    task automatic test_zero();
        int t, a0, w0, d0;
        a0 = mon_aw_addr.size(); w0 = mon_w_len.size(); d0 = n_done;
        start(64'h123, 0, t);
        repeat (5) tick();
        checks++;
        if (n_done - d0 != 1 || last_done_cyc != t + 2) begin
            errors++;
            $display("FAIL zero_done: pulses %0d at t+%0d expected 1 at t+2", n_done - d0, last_done_cyc - t);
        end
        checks++;
        if (mon_aw_addr.size() != a0 || mon_w_len.size() != w0) begin
            errors++;
            $display("FAIL zero_no_burst: aw=%0d w=%0d expected 0 0", mon_aw_addr.size() - a0, mon_w_len.size() - w0);
        end
    endtask

    task automatic test_outstanding();
        int t, a0, b0, d0, bad;
        a0 = mon_aw_addr.size(); b0 = n_b; d0 = n_done;
        p_aw = 100; p_w = 100; p_b = 0; max_pend = 0;
        start(64'h0, 1280, t);
        repeat (40) tick();
        checks++;
        if (mon_aw_addr.size() - a0 != 16 || m_axi_awvalid !== 1'b0) begin
            errors++;
            $display("FAIL out_limit: aw=%0d awvalid=%b expected 16 0", mon_aw_addr.size() - a0, m_axi_awvalid);
        end
        m_axi_bvalid = 1'b1;
        repeat (10) tick();
        checks++;
        if (mon_aw_addr.size() - a0 != 17) begin
            errors++;
            $display("FAIL out_one_b: aw=%0d expected 17", mon_aw_addr.size() - a0);
        end
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b1;
        repeat (10) tick();
        checks++;
        if (mon_aw_addr.size() - a0 != 19 || n_done != d0) begin
            errors++;
            $display("FAIL out_simul: aw=%0d done=%0d expected 19 0", mon_aw_addr.size() - a0, n_done - d0);
        end
        p_b = 100;
        wait_done(d0, 400, "out");
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < 20 && a0 + i < mon_aw_addr.size(); i++)
            if (mon_aw_addr[a0+i] !== 64'(i) * 64'h1000 || mon_aw_len[a0+i] != 63) bad++;
        checks++;
        if (mon_aw_addr.size() - a0 != 20 || bad != 0 || n_b - b0 != 20) begin
            errors++;
            $display("FAIL out_bursts: aw=%0d bad=%0d b=%0d expected 20 0 20", mon_aw_addr.size() - a0, bad, n_b - b0);
        end
        checks++;
        if (last_done_cyc != last_b_cyc + 1 || n_done - d0 != 1 || max_pend > 16) begin
            errors++;
            $display("FAIL out_done: done-lastB=%0d pulses=%0d max_pend=%0d expected 1 1 <=16", last_done_cyc - last_b_cyc, n_done - d0, max_pend);
        end
    endtask

    task automatic test_wlen_stall();
        int t, a0, w0, d0;
        a0 = mon_aw_addr.size(); w0 = mon_w_len.size(); d0 = n_done;
        p_aw = 100; p_w = 0; p_b = 100;
        start(64'hF00, 100, t);
        repeat (6) tick();
        checks++;
        if (mon_aw_addr.size() - a0 != 1 || m_axi_awvalid !== 1'b0 || wlen_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: aw=%0d awvalid=%b wlen_valid=%b expected 1 0 1", mon_aw_addr.size() - a0, m_axi_awvalid, wlen_valid);
        end
        p_w = 100;
        wait_done(d0, 200, "stall");
        repeat (3) tick();
        checks++;
        if (mon_aw_addr.size() - a0 != 3 || mon_w_len.size() - w0 != 3) begin
            errors++;
            $display("FAIL stall_count: aw=%0d w=%0d expected 3 3", mon_aw_addr.size() - a0, mon_w_len.size() - w0);
        end else begin
            checks++;
            if (mon_aw_addr[a0] !== 64'hF00 || mon_aw_addr[a0+1] !== 64'h1000 || mon_aw_addr[a0+2] !== 64'h2000 ||
                mon_aw_len[a0] != 3 || mon_aw_len[a0+1] != 63 || mon_aw_len[a0+2] != 31) begin
                errors++;
                $display("FAIL stall_aw: got %h/%0d %h/%0d %h/%0d expected f00/3 1000/63 2000/31", mon_aw_addr[a0], mon_aw_len[a0],
                         mon_aw_addr[a0+1], mon_aw_len[a0+1], mon_aw_addr[a0+2], mon_aw_len[a0+2]);
            end
            checks++;
            if (mon_w_len[w0] != 3 || mon_w_len[w0+1] != 63 || mon_w_len[w0+2] != 31 || mon_aw_cyc[a0+1] != mon_w_cyc[w0] + 1) begin
                errors++;
                $display("FAIL stall_order: wlen %0d %0d %0d, 2nd AW %0d cycles after 1st wlen; expected 3 63 31, 1",
                         mon_w_len[w0], mon_w_len[w0+1], mon_w_len[w0+2], mon_aw_cyc[a0+1] - mon_w_cyc[w0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t, a0, d0;
        p_aw = 100; p_w = 100; p_b = 0;
        start(64'h0, 1280, t);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_axi_awvalid, wlen_valid, ctrl_done, m_axi_bready} !== 4'b0 || m_axi_awaddr !== 64'h0 || {m_axi_awlen, wlen} !== 16'h0) begin
            errors++;
            $display("FAIL midreset_outputs: valids/done/bready=%b awaddr=%h awlen=%h wlen=%h expected all 0",
                     {m_axi_awvalid, wlen_valid, ctrl_done, m_axi_bready}, m_axi_awaddr, m_axi_awlen, wlen);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        pend_adj = mon_aw_addr.size() - n_b;
        d0 = n_done;
        p_b = 100;
        repeat (10) tick();
        checks++;
        if (n_done != d0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d pulses expected 0", n_done - d0);
        end
        a0 = mon_aw_addr.size();
        start(64'h2000, 64, t);
        wait_done(d0, 200, "midreset");
        repeat (3) tick();
        checks++;
        if (mon_aw_addr.size() - a0 != 1 || n_done - d0 != 1 || (mon_aw_addr.size() > a0 && (mon_aw_addr[a0] !== 64'h2000 || mon_aw_len[a0] != 63))) begin
            errors++;
            $display("FAIL midreset_restart: aw=%0d done=%0d expected one burst 2000/63 and one done", mon_aw_addr.size() - a0, n_done - d0);
        end
    endtask

    task automatic test_random();
        int t, a0, w0, d0, n, bad, exp_done, last_hs;
        logic [63:0] a;
        for (int it = 0; it < 12; it++) begin
            a0 = mon_aw_addr.size(); w0 = mon_w_len.size(); d0 = n_done;
            a = {$urandom, $urandom};
            n = int'($urandom_range(300));
            if (it == 0) n = 0;
            p_aw = int'($urandom_range(100, 30));
            p_w = int'($urandom_range(100, 30));
            p_b = int'($urandom_range(100, 20));
            max_pend = 0;
            build_model(a, n);
            start(a, n, t);
            wait_done(d0, 3000, "rand");
            repeat (3) tick();
            bad = 0;
            for (int i = 0; i < exp_addr.size(); i++) begin
                if (a0 + i >= mon_aw_addr.size() || mon_aw_addr[a0+i] !== exp_addr[i] || mon_aw_len[a0+i] != exp_len[i]) bad++;
                if (w0 + i >= mon_w_len.size() || mon_w_len[w0+i] != exp_len[i]) bad++;
            end
            checks++;
            if (bad != 0 || mon_aw_addr.size() - a0 != exp_addr.size() || mon_w_len.size() - w0 != exp_addr.size()) begin
                errors++;
                $display("FAIL rand_bursts: addr=%h beats=%0d aw=%0d w=%0d bad=%0d expected %0d bursts", a, n,
                         mon_aw_addr.size() - a0, mon_w_len.size() - w0, bad, exp_addr.size());
            end
            exp_done = t + 2;
            if (n > 0 && mon_aw_cyc.size() > a0 && mon_w_cyc.size() > w0) begin
                last_hs = mon_aw_cyc[$] > mon_w_cyc[$] ? mon_aw_cyc[$] : mon_w_cyc[$];
                exp_done = last_b_cyc + 1 > last_hs + 2 ? last_b_cyc + 1 : last_hs + 2;
            end
            checks++;
            if (n_done - d0 != 1 || last_done_cyc != exp_done || max_pend > 16) begin
                errors++;
                $display("FAIL rand_done: beats=%0d pulses=%0d done at t+%0d expected t+%0d max_pend=%0d", n, n_done - d0,
                         last_done_cyc - t, exp_done - t, max_pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_4k();
        test_zero();
        test_outstanding();
        test_wlen_stall();
        test_reset_mid();
        test_random();
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("FAIL valid_stability: %0d cycles where a pending valid dropped or its payload changed, expected 0", stab_err);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
